// File: rtl/ss_score_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ss_score_decoder
// Brief    : Receive end of a multiplexed two-digit seven-segment score link.
//            Decodes the tens/ones segment buses back to BCD, checks frame
//            integrity, and publishes a binary score once it has been stable
//            for STABLE_FRAMES consecutive good frames.
// Revision : 1.0 - initial release
// ============================================================================
module ss_score_decoder #(
    parameter int STABLE_FRAMES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             phase,
    input  logic [6:0]       ss0,
    input  logic [6:0]       ss1,
    output logic [6:0]       score,
    output logic [3:0]       tens,
    output logic [3:0]       ones,
    output logic             score_valid,
    output logic             locked,
    output logic             frame_err,
    output logic [ERR_W-1:0] err_count
);

    // Stability counter only needs to reach STABLE_FRAMES, where it saturates.
    localparam int                 c_CNT_W    = $clog2(STABLE_FRAMES + 1);
    localparam logic [c_CNT_W-1:0] c_STABLE   = c_CNT_W'(STABLE_FRAMES);
    localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);

    localparam logic [0:0]         c_SYNC     = 1'b0;
    localparam logic [0:0]         c_GOT_TENS = 1'b1;

    // Returns {legal, digit}; anything outside the ten digit glyphs is illegal.
    function automatic logic [4:0] f_decode(input logic [6:0] seg);
        case (seg)
            7'b0111111: return {1'b1, 4'd0};
            7'b0000110: return {1'b1, 4'd1};
            7'b1011011: return {1'b1, 4'd2};
            7'b1001111: return {1'b1, 4'd3};
            7'b1100110: return {1'b1, 4'd4};
            7'b1101101: return {1'b1, 4'd5};
            7'b1111101: return {1'b1, 4'd6};
            7'b0000111: return {1'b1, 4'd7};
            7'b1111111: return {1'b1, 4'd8};
            7'b1100111: return {1'b1, 4'd9};
            default:    return 5'b0_0000;
        endcase
    endfunction

    logic [0:0]         r_state;
    logic [3:0]         r_tens_hold;
    logic [3:0]         r_cand_tens;
    logic [3:0]         r_cand_ones;
    logic [c_CNT_W-1:0] r_stab_cnt;
    logic [6:0]         r_score;
    logic [3:0]         r_tens;
    logic [3:0]         r_ones;
    logic               r_score_valid;
    logic               r_locked;
    logic               r_frame_err;
    logic [ERR_W-1:0]   r_err_count;

    logic [6:0]         w_active;
    logic [6:0]         w_inactive;
    logic [4:0]         w_dec;
    logic [3:0]         w_digit;
    logic               w_good;
    logic               w_complete;
    logic               w_err;
    logic               w_match;
    logic [c_CNT_W-1:0] w_stab_next;
    logic               w_reached;
    logic               w_differs;
    logic               w_publish;
    logic [6:0]         w_score;

    // The phase bit selects which bus must carry a digit; the other must be blank.
    assign w_active   = phase ? ss0 : ss1;
    assign w_inactive = phase ? ss1 : ss0;
    assign w_dec      = f_decode(w_active);
    assign w_digit    = w_dec[3:0];
    assign w_good     = w_dec[4] && (w_inactive == 7'd0);

    // A frame completes on a good ones sample that directly follows a tens sample.
    assign w_complete = (r_state == c_GOT_TENS) && phase && w_good;

    // Bad tens sample in SYNC, or anything other than a good ones sample in GOT_TENS.
    assign w_err = ((r_state == c_SYNC) && !phase && !w_good) ||
                   ((r_state == c_GOT_TENS) && !(phase && w_good));

    assign w_match     = ({r_tens_hold, w_digit} == {r_cand_tens, r_cand_ones});
    assign w_stab_next = !w_match               ? c_ONE    :
                         (r_stab_cnt == c_STABLE) ? c_STABLE :
                         r_stab_cnt + c_ONE;

    // Publish only on the transition into STABLE_FRAMES; a new candidate counts
    // as a transition, which makes STABLE_FRAMES=1 publish each new value.
    assign w_reached = (w_stab_next == c_STABLE) && (!w_match || (r_stab_cnt != c_STABLE));
    assign w_differs = !r_locked || ({r_tens_hold, w_digit} != {r_tens, r_ones});
    assign w_publish = w_complete && w_reached && w_differs;

    assign w_score = 7'(r_tens_hold) * 7'd10 + 7'(w_digit);

    // Frame FSM, stability tracking, publishing and error accounting.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_state       <= c_SYNC;
            r_tens_hold   <= 4'd0;
            r_cand_tens   <= 4'd0;
            r_cand_ones   <= 4'd0;
            r_stab_cnt    <= '0;
            r_score       <= 7'd0;
            r_tens        <= 4'd0;
            r_ones        <= 4'd0;
            r_score_valid <= 1'b0;
            r_locked      <= 1'b0;
            r_frame_err   <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_score_valid <= 1'b0;
            r_frame_err   <= w_err;

            case (r_state)
                c_SYNC: begin
                    if (!phase && w_good) begin
                        r_tens_hold <= w_digit;
                        r_state     <= c_GOT_TENS;
                    end
                end
                default: begin
                    r_state <= c_SYNC;
                end
            endcase

            if (w_err) begin
                r_stab_cnt <= '0;
                if (r_err_count != {ERR_W{1'b1}}) begin
                    r_err_count <= r_err_count + 1'b1;
                end
            end else if (w_complete) begin
                r_stab_cnt  <= w_stab_next;
                r_cand_tens <= r_tens_hold;
                r_cand_ones <= w_digit;
            end

            if (w_publish) begin
                r_tens        <= r_tens_hold;
                r_ones        <= w_digit;
                r_score       <= w_score;
                r_score_valid <= 1'b1;
                r_locked      <= 1'b1;
            end
        end
    end

    assign score       = r_score;
    assign tens        = r_tens;
    assign ones        = r_ones;
    assign score_valid = r_score_valid;
    assign locked      = r_locked;
    assign frame_err   = r_frame_err;
    assign err_count   = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_ss_score_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ss_score_decoder
// Brief    : Table-driven self-checking bench for ss_score_decoder, plus a
//            short hand-written sequence on a STABLE_FRAMES=1 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ss_score_decoder;

    logic       clk = 1'b0;
    logic       nRst;
    logic       phase;
    logic [6:0] ss0;
    logic [6:0] ss1;

    logic [6:0] score;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       score_valid;
    logic       locked;
    logic       frame_err;
    logic [7:0] err_count;

    logic [6:0] s1_score;
    logic [3:0] s1_tens;
    logic [3:0] s1_ones;
    logic       s1_valid;
    logic       s1_locked;
    logic       s1_err;
    logic [7:0] s1_err_count;

    always #5 clk = ~clk;

    ss_score_decoder #(.STABLE_FRAMES(4), .ERR_W(8)) dut (
        .clk(clk), .nRst(nRst), .phase(phase), .ss0(ss0), .ss1(ss1),
        .score(score), .tens(tens), .ones(ones), .score_valid(score_valid),
        .locked(locked), .frame_err(frame_err), .err_count(err_count)
    );

    ss_score_decoder #(.STABLE_FRAMES(1), .ERR_W(8)) dut_sf1 (
        .clk(clk), .nRst(nRst), .phase(phase), .ss0(ss0), .ss1(ss1),
        .score(s1_score), .tens(s1_tens), .ones(s1_ones), .score_valid(s1_valid),
        .locked(s1_locked), .frame_err(s1_err), .err_count(s1_err_count)
    );

    typedef struct {
        logic       nrst;
        logic       ph;
        logic [6:0] s0;
        logic [6:0] s1;
        logic       ev;
        logic       ee;
        int         score;
        logic       lk;
        int         errs;
    } vec_t;

    vec_t       vecs[$];
    logic [6:0] seg[10];
    int         e_score;
    logic       e_lk;
    int         e_errs;
    int         n_chk;
    int         n_fail;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    // One cycle of stimulus; expectations are the outputs after that edge.
    task automatic add_rec(input logic nr, input logic ph, input logic [6:0] s0, input logic [6:0] s1,
                           input logic ev, input logic ee, input int sc);
        vec_t v;
        if (!nr) begin
            e_score = 0; e_lk = 1'b0; e_errs = 0;
        end else begin
            if (ee && e_errs < 255) e_errs++;
            if (ev) begin e_score = sc; e_lk = 1'b1; end
        end
        v.nrst = nr; v.ph = ph; v.s0 = s0; v.s1 = s1; v.ev = ev; v.ee = ee;
        v.score = e_score; v.lk = e_lk; v.errs = e_errs;
        vecs.push_back(v);
    endtask

    task automatic add_frame(input int t, input int o, input logic pub, input int sc);
        add_rec(1'b1, 1'b0, 7'd0, seg[t], 1'b0, 1'b0, 0);
        add_rec(1'b1, 1'b1, seg[o], 7'd0, pub, 1'b0, sc);
    endtask

    task automatic drive(input logic nr, input logic ph, input logic [6:0] s0, input logic [6:0] s1);
        nRst = nr; phase = ph; ss0 = s0; ss1 = s1;
        @(posedge clk);
        #1;
    endtask

    // Hand sequence on the STABLE_FRAMES=1 instance: checks pulse and score.
    task automatic sf1_frame(input int t, input int o, input logic pub, input int sc, input int idx);
        drive(1'b1, 1'b0, 7'd0, seg[t]);
        chk("sf1_tens_valid", idx, 32'(s1_valid), 32'd0);
        drive(1'b1, 1'b1, seg[o], 7'd0);
        chk("sf1_valid", idx, 32'(s1_valid), 32'(pub));
        chk("sf1_score", idx, 32'(s1_score), 32'(sc));
    endtask

    initial begin
        seg = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1100111};
        n_chk = 0; n_fail = 0;
        e_score = 0; e_lk = 1'b0; e_errs = 0;
        nRst = 1'b0; phase = 1'b0; ss0 = 7'd0; ss1 = 7'd0;

        // Reset
        add_rec(1'b0, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 0);
        add_rec(1'b0, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 0);
        // First publish of 42 after four frames
        for (int i = 0; i < 3; i++) add_frame(4, 2, 1'b0, 0);
        add_frame(4, 2, 1'b1, 42);
        // Repeated identical frames never re-pulse
        for (int i = 0; i < 10; i++) add_frame(4, 2, 1'b0, 0);
        // 17 x3, glitch 18, 17 x4 -> single publish of 17
        for (int i = 0; i < 3; i++) add_frame(1, 7, 1'b0, 0);
        add_frame(1, 8, 1'b0, 0);
        for (int i = 0; i < 3; i++) add_frame(1, 7, 1'b0, 0);
        add_frame(1, 7, 1'b1, 17);
        // "A" glyph in ones slot, then 43 re-qualifies
        add_rec(1'b1, 1'b0, 7'd0, seg[4], 1'b0, 1'b0, 0);
        add_rec(1'b1, 1'b1, 7'b1110111, 7'd0, 1'b0, 1'b1, 0);
        for (int i = 0; i < 3; i++) add_frame(4, 3, 1'b0, 0);
        add_frame(4, 3, 1'b1, 43);
        // Phase held low twice, ss0 active during phase 0, idle phase 1
        add_rec(1'b1, 1'b0, 7'd0, seg[4], 1'b0, 1'b0, 0);
        add_rec(1'b1, 1'b0, 7'd0, seg[4], 1'b0, 1'b1, 0);
        add_rec(1'b1, 1'b0, seg[1], seg[4], 1'b0, 1'b1, 0);
        add_rec(1'b1, 1'b1, seg[3], 7'd0, 1'b0, 1'b0, 0);
        // Inactive tens bus nonzero during ones slot; blank tens glyph
        add_rec(1'b1, 1'b0, 7'd0, seg[2], 1'b0, 1'b0, 0);
        add_rec(1'b1, 1'b1, seg[2], seg[2], 1'b0, 1'b1, 0);
        add_rec(1'b1, 1'b0, 7'd0, 7'd0, 1'b0, 1'b1, 0);
        for (int i = 0; i < 3; i++) add_frame(0, 5, 1'b0, 0);
        add_frame(0, 5, 1'b1, 5);
        // Error counter saturation
        for (int i = 0; i < 260; i++) add_rec(1'b1, 1'b0, 7'd0, 7'd0, 1'b0, 1'b1, 0);
        // Reset mid-frame discards the held tens; orphan ones sample is ignored
        add_rec(1'b1, 1'b0, 7'd0, seg[3], 1'b0, 1'b0, 0);
        add_rec(1'b0, 1'b1, seg[4], 7'd0, 1'b0, 1'b0, 0);
        add_rec(1'b1, 1'b1, seg[4], 7'd0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) add_frame(0, 0, 1'b0, 0);
        add_frame(0, 0, 1'b1, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].nrst, vecs[i].ph, vecs[i].s0, vecs[i].s1);
            chk("score_valid", i, 32'(score_valid), 32'(vecs[i].ev));
            chk("frame_err",   i, 32'(frame_err),   32'(vecs[i].ee));
            chk("score",       i, 32'(score),       32'(vecs[i].score));
            chk("tens",        i, 32'(tens),        32'(vecs[i].score / 10));
            chk("ones",        i, 32'(ones),        32'(vecs[i].score % 10));
            chk("locked",      i, 32'(locked),      32'(vecs[i].lk));
            chk("err_count",   i, 32'(err_count),   32'(vecs[i].errs));
        end

        // STABLE_FRAMES=1 corner cases
        drive(1'b0, 1'b0, 7'd0, 7'd0);
        chk("sf1_reset_locked", 0, 32'(s1_locked), 32'd0);
        sf1_frame(2, 3, 1'b1, 23, 1);
        sf1_frame(2, 3, 1'b0, 23, 2);
        sf1_frame(3, 1, 1'b1, 31, 3);
        drive(1'b1, 1'b0, 7'd0, 7'd0);
        chk("sf1_err", 4, 32'(s1_err), 32'd1);
        sf1_frame(3, 1, 1'b0, 31, 5);
        sf1_frame(2, 3, 1'b1, 23, 6);
        chk("sf1_locked", 7, 32'(s1_locked), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
